// File: rtl/pr_sched_pkg.sv
// Shared types and pr_ip status encodings for the partial-reconfiguration scheduler.
package pr_sched_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FREEZE      = 4'd1,
        START       = 4'd2,
        WAIT_BUSY   = 4'd3,
        STREAM      = 4'd4,
        WAIT_DONE   = 4'd5,
        FAIL        = 4'd6,
        RELEASE_OK  = 4'd7,
        RELEASE_ERR = 4'd8
    } state_t;

    localparam logic [2:0] ST_IDLE        = 3'b000;
    localparam logic [2:0] ST_PR_ERROR    = 3'b001;
    localparam logic [2:0] ST_CRC_ERROR   = 3'b010;
    localparam logic [2:0] ST_INCOMPAT    = 3'b011;
    localparam logic [2:0] ST_IN_PROGRESS = 3'b100;
    localparam logic [2:0] ST_SUCCESS     = 3'b101;
    localparam logic [2:0] ERR_TIMEOUT    = 3'b111;

    function automatic logic is_err_status(input logic [2:0] s);
        return (s == ST_PR_ERROR) || (s == ST_CRC_ERROR) || (s == ST_INCOMPAT);
    endfunction

endpackage

// File: rtl/pr_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer only moves when both inputs contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       pointer
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pointer <= 1'b0;
        else if (advance && (&req))
            pointer <= ~pointer;
    end

endmodule

// File: rtl/pr_sched.sv
// Shares one pr_ip between two PR regions: arbitrate, freeze, start, stream, release.
module pr_sched
    import pr_sched_pkg::*;
#(
    parameter int FREEZE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DATA_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [2*DATA_W-1:0] s_data,
    input  logic [1:0]          s_valid,
    input  logic [1:0]          s_last,
    output logic [1:0]          s_ready,
    output logic [1:0]          done,
    output logic [1:0]          err,
    output logic [2:0]          err_code,
    output logic [1:0]          grant,
    output logic                busy,
    output logic [1:0]          freeze,
    output logic                pr_start,
    output logic [DATA_W-1:0]   pr_data,
    output logic                pr_data_valid,
    input  logic                pr_data_ready,
    input  logic [2:0]          pr_status
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRZ_END = CNT_W'(FREEZE_CYCLES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_restart;
    logic [2:0]       fail_code, fail_d;
    logic [1:0]       arb_grant;
    logic             arb_pointer_unused;
    logic             gsel;
    logic             xfer;
    logic             timeout;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (state == IDLE),
        .grant   (arb_grant),
        .pointer (arb_pointer_unused)
    );

    assign gsel    = grant[1];
    assign timeout = (cnt >= TO_LAST);
    assign xfer    = (state == STREAM) && s_valid[gsel] && pr_data_ready;

    always_comb begin
        state_d     = state;
        fail_d      = fail_code;
        cnt_restart = 1'b0;
        case (state)
            IDLE:      if (|req) state_d = FREEZE;
            FREEZE:    if (cnt == FRZ_END) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (pr_status == ST_IN_PROGRESS) begin
                    state_d = STREAM;
                end else if (is_err_status(pr_status)) begin
                    state_d = FAIL;
                    fail_d  = pr_status;
                end else if (timeout) begin
                    state_d = FAIL;
                    fail_d  = ERR_TIMEOUT;
                end
            end
            // Error status beats a simultaneous last-word transfer; any transfer re-arms the timeout.
            STREAM: begin
                if (is_err_status(pr_status)) begin
                    state_d = FAIL;
                    fail_d  = pr_status;
                end else if (xfer && s_last[gsel]) begin
                    state_d = WAIT_DONE;
                end else if (xfer) begin
                    cnt_restart = 1'b1;
                end else if (timeout) begin
                    state_d = FAIL;
                    fail_d  = ERR_TIMEOUT;
                end
            end
            WAIT_DONE: begin
                if (pr_status == ST_SUCCESS) begin
                    state_d = RELEASE_OK;
                end else if (is_err_status(pr_status)) begin
                    state_d = FAIL;
                    fail_d  = pr_status;
                end else if (timeout) begin
                    state_d = FAIL;
                    fail_d  = ERR_TIMEOUT;
                end
            end
            FAIL:        state_d = RELEASE_ERR;
            RELEASE_OK:  state_d = IDLE;
            RELEASE_ERR: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            cnt       <= '0;
            fail_code <= '0;
            err_code  <= '0;
        end else begin
            state     <= state_d;
            fail_code <= fail_d;
            if (state_d == IDLE)
                grant <= '0;
            else if (state == IDLE)
                grant <= arb_grant;
            if ((state_d != state) || cnt_restart)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
            if (state == FAIL)
                err_code <= fail_code;
        end
    end

    always_comb begin
        pr_data       = '0;
        pr_data_valid = 1'b0;
        s_ready       = '0;
        if (state == STREAM) begin
            pr_data       = gsel ? s_data[2*DATA_W-1:DATA_W] : s_data[DATA_W-1:0];
            pr_data_valid = s_valid[gsel];
            s_ready[gsel] = pr_data_ready;
        end
    end

    assign freeze   = ((state != IDLE) && (state != RELEASE_OK) && (state != RELEASE_ERR)) ? grant : '0;
    assign pr_start = (state == START);
    assign done     = (state == RELEASE_OK)  ? grant : '0;
    assign err      = (state == RELEASE_ERR) ? grant : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pr_sched.sv
// Self-checking bench for pr_sched: behavioural pr_ip and bitstream sources, per-scenario tasks.
module tb_pr_sched;
    localparam int F = 16;
    localparam int T = 50;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req, s_valid, s_last, s_ready, done, err, grant, freeze;
    logic [2*W-1:0] s_data;
    logic [2:0]     err_code, pr_status;
    logic           busy, pr_start, pr_data_valid, pr_data_ready;
    logic [W-1:0]   pr_data;

    pr_sched #(.FREEZE_CYCLES(F), .TIMEOUT_CYCLES(T), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .done(done), .err(err),
        .err_code(err_code), .grant(grant), .busy(busy), .freeze(freeze),
        .pr_start(pr_start), .pr_data(pr_data), .pr_data_valid(pr_data_valid),
        .pr_data_ready(pr_data_ready), .pr_status(pr_status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // sources and received words per requester
    logic [W-1:0] src [2][64];
    logic [W-1:0] rx  [2][64];
    int src_n[2], src_idx[2], rx_n[2];
    bit gaps, rnd_ready;

    // behavioural pr_ip: 0 normal, 1 stuck at idle, 2 error after err_at words
    int         ip_mode, ip_phase, ip_delay, ip_words, err_at;
    logic [2:0] ip_status, err_val;

    int         cyc, pstart_cnt, pstart_cyc, err_cyc, freeze_run, freeze_at_start;
    int         done_cnt[2], err_cnt[2], done_seq[$];
    int         viol_ready, viol_freeze, px, sx, first_err_cyc;
    logic [2:0] code_at_err;
    logic [1:0] freeze_at_rel, grant_at_rel;
    logic       valid_after_err;

    task automatic clear_stats();
        pstart_cnt = 0; pstart_cyc = 0; err_cyc = 0; freeze_run = 0; freeze_at_start = -1;
        for (int r = 0; r < 2; r++) begin done_cnt[r] = 0; err_cnt[r] = 0; end
        done_seq.delete();
        viol_ready = 0; viol_freeze = 0; px = 0; sx = 0; first_err_cyc = -1;
        code_at_err = 3'bxxx; freeze_at_rel = 2'bxx; grant_at_rel = 2'bxx; valid_after_err = 1'bx;
    endtask

    task automatic model_reset();
        ip_phase = 0; ip_status = 3'b000; ip_words = 0; ip_delay = 0;
        req = 2'b00;
        for (int r = 0; r < 2; r++) begin src_n[r] = 0; src_idx[r] = 0; rx_n[r] = 0; end
    endtask

    task automatic load(input int r, input int n);
        src_n[r] = n; src_idx[r] = 0; rx_n[r] = 0;
        for (int i = 0; i < n; i++) src[r][i] = W'($urandom);
        req[r] = 1'b1;
    endtask

    function automatic int data_bad(input int r);
        int b;
        b = (rx_n[r] != src_n[r]) ? 1 : 0;
        for (int i = 0; i < rx_n[r] && i < 64; i++)
            if (rx[r][i] !== src[r][i]) b++;
        return b;
    endfunction

    task automatic step();
        logic ok;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            ok = (src_idx[r] < src_n[r]) && (!gaps || ($urandom_range(0, 2) != 0));
            s_valid[r]       = ok;
            s_data[r*W +: W] = ok ? src[r][src_idx[r]] : W'($urandom);
            s_last[r]        = ok && (src_idx[r] == src_n[r] - 1);
        end
        pr_data_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        pr_status     = ip_status;
        #1;
        cyc++;
        if (cyc == first_err_cyc + 1 && first_err_cyc >= 0) valid_after_err = pr_data_valid;
        if (first_err_cyc < 0 && pr_status inside {3'b001, 3'b010, 3'b011}) first_err_cyc = cyc;
        if (pr_start) begin
            pstart_cnt++; pstart_cyc = cyc; freeze_at_start = freeze_run; ip_words = 0;
            if (ip_mode != 1) begin ip_phase = 1; ip_delay = $urandom_range(1, 4); end
        end else if (ip_phase == 1) begin
            ip_delay--;
            if (ip_delay == 0) begin ip_status = 3'b100; ip_phase = 2; end
        end else if (ip_phase == 3) begin
            ip_delay--;
            if (ip_delay == 0) begin ip_status = 3'b101; ip_phase = 0; end
        end
        if (pr_data_valid && pr_data_ready) px++;
        for (int r = 0; r < 2; r++) begin
            if (s_valid[r] && s_ready[r]) begin
                sx++;
                if (!(pr_data_valid && pr_data_ready)) viol_ready++;
                if (rx_n[r] < 64) rx[r][rx_n[r]] = pr_data;
                rx_n[r]++;
                ip_words++;
                if (s_last[r] && ip_phase == 2 && ip_mode == 0) begin
                    ip_phase = 3; ip_delay = $urandom_range(1, 3);
                end
                src_idx[r]++;
            end
            if (s_ready[r] && !grant[r]) viol_ready++;
        end
        if (ip_phase == 2 && ip_mode == 2 && ip_words >= err_at) begin
            ip_status = err_val; ip_phase = 0;
        end
        if (freeze != 2'b00) freeze_run++; else freeze_run = 0;
        if ((freeze & ~grant) != 2'b00 || freeze == 2'b11) viol_freeze++;
        for (int r = 0; r < 2; r++) begin
            if (done[r] || err[r]) begin
                freeze_at_rel = freeze; grant_at_rel = grant;
                req[r] = 1'b0; ip_status = 3'b000; ip_phase = 0;
            end
            if (done[r]) begin done_cnt[r]++; done_seq.push_back(r); end
            if (err[r]) begin
                err_cnt[r]++; code_at_err = err_code; err_cyc = cyc; src_n[r] = src_idx[r];
            end
        end
    endtask

    task automatic run_until(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (req == 2'b00 && !busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        s_valid = '0; s_last = '0; s_data = '0; pr_data_ready = 1'b0; pr_status = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        s_valid = '0; s_last = '0; s_data = '0; pr_data_ready = 1'b1; pr_status = 3'b100;
        req = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, freeze, done, err, s_ready} !== 10'b0) begin
            errors++; $display("FAIL reset_vec: got %b want 0", {grant, freeze, done, err, s_ready});
        end
        checks++;
        if ({busy, pr_start, pr_data_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b want 000", {busy, pr_start, pr_data_valid});
        end
        checks++;
        if (err_code !== 3'b000) begin errors++; $display("FAIL reset_code: got %b want 000", err_code); end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        do_reset(); clear_stats();
        ip_mode = 0; gaps = 0; rnd_ready = 0;
        load(0, 4);
        run_until(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_run: got no completion want done"); end
        checks++;
        if (pstart_cnt != 1) begin errors++; $display("FAIL single_pr_start: got %0d pulses want 1", pstart_cnt); end
        checks++;
        if (freeze_at_start < F || freeze_at_start > F + 2) begin
            errors++; $display("FAIL single_freeze_len: got %0d want %0d..%0d", freeze_at_start, F, F + 2);
        end
        checks++;
        if (data_bad(0) != 0) begin errors++; $display("FAIL single_data: got %0d bad of %0d want 0", data_bad(0), rx_n[0]); end
        checks++;
        if (done_cnt[0] != 1 || err_cnt[0] != 0) begin
            errors++; $display("FAIL single_done: got done=%0d err=%0d want 1/0", done_cnt[0], err_cnt[0]);
        end
        checks++;
        if (freeze_at_rel !== 2'b00 || grant_at_rel !== 2'b01) begin
            errors++; $display("FAIL single_release: got freeze=%b grant=%b want 00/01", freeze_at_rel, grant_at_rel);
        end
        checks++;
        if (err_code !== 3'b000 || freeze !== 2'b00) begin
            errors++; $display("FAIL single_after: got code=%b freeze=%b want 000/00", err_code, freeze);
        end
    endtask

    task automatic test_contention();
        bit ok;
        do_reset(); clear_stats();
        ip_mode = 0; gaps = 0; rnd_ready = 0;
        load(0, 3); load(1, 3);
        run_until(400, ok);
        checks++;
        if (!ok || done_seq.size() != 2) begin
            errors++; $display("FAIL rr_first_run: got ok=%0d dones=%0d want 1/2", ok, done_seq.size());
        end else begin
            checks++;
            if (done_seq[0] != 0 || done_seq[1] != 1) begin
                errors++; $display("FAIL rr_first_order: got %0d,%0d want 0,1", done_seq[0], done_seq[1]);
            end
        end
        checks++;
        if (data_bad(0) + data_bad(1) != 0) begin
            errors++; $display("FAIL rr_first_data: got %0d bad want 0", data_bad(0) + data_bad(1));
        end
        clear_stats();
        load(0, 2); load(1, 2);
        run_until(400, ok);
        checks++;
        if (!ok || done_seq.size() != 2) begin
            errors++; $display("FAIL rr_second_run: got ok=%0d dones=%0d want 1/2", ok, done_seq.size());
        end else begin
            checks++;
            if (done_seq[0] != 1 || done_seq[1] != 0) begin
                errors++; $display("FAIL rr_second_order: got %0d,%0d want 1,0", done_seq[0], done_seq[1]);
            end
        end
        checks++;
        if (viol_freeze != 0) begin errors++; $display("FAIL rr_freeze_onehot: got %0d violations want 0", viol_freeze); end
    endtask

    task automatic test_stream_error();
        bit ok;
        clear_stats();
        ip_mode = 2; err_at = 2; err_val = 3'b010; gaps = 0; rnd_ready = 0;
        load(1, 6);
        run_until(300, ok);
        checks++;
        if (!ok || err_cnt[1] != 1 || done_cnt[1] != 0) begin
            errors++; $display("FAIL serr_pulse: got ok=%0d err=%0d done=%0d want 1/1/0", ok, err_cnt[1], done_cnt[1]);
        end
        checks++;
        if (code_at_err !== 3'b010) begin errors++; $display("FAIL serr_code: got %b want 010", code_at_err); end
        checks++;
        if (valid_after_err !== 1'b0) begin
            errors++; $display("FAIL serr_valid_stop: got %b want 0", valid_after_err);
        end
        checks++;
        if (freeze_at_rel !== 2'b00 || freeze !== 2'b00 || rx_n[1] >= 6) begin
            errors++; $display("FAIL serr_release: got freeze=%b/%b words=%0d want 00/00/<6", freeze_at_rel, freeze, rx_n[1]);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_stats();
        ip_mode = 1; gaps = 0; rnd_ready = 0;
        load(0, 4);
        run_until(400, ok);
        checks++;
        if (!ok || err_cnt[0] != 1 || done_cnt[0] != 0) begin
            errors++; $display("FAIL tmo_pulse: got ok=%0d err=%0d done=%0d want 1/1/0", ok, err_cnt[0], done_cnt[0]);
        end
        checks++;
        if (code_at_err !== 3'b111) begin errors++; $display("FAIL tmo_code: got %b want 111", code_at_err); end
        checks++;
        if (err_cyc - pstart_cyc < T || err_cyc - pstart_cyc > T + 3) begin
            errors++; $display("FAIL tmo_latency: got %0d want %0d..%0d", err_cyc - pstart_cyc, T, T + 3);
        end
        checks++;
        if (freeze_at_rel !== 2'b00 || rx_n[0] != 0) begin
            errors++; $display("FAIL tmo_release: got freeze=%b words=%0d want 00/0", freeze_at_rel, rx_n[0]);
        end
    endtask

    task automatic test_random_stream();
        bit ok;
        int r, both, exp0, exp1;
        ip_mode = 0; gaps = 1; rnd_ready = 1;
        clear_stats();
        exp0 = 0; exp1 = 0;
        for (int it = 0; it < 5; it++) begin
            r = $urandom_range(0, 1);
            both = $urandom_range(0, 2) == 0;
            load(r, $urandom_range(1, 12));
            if (r == 0) exp0++; else exp1++;
            if (both) begin
                load(1 - r, $urandom_range(1, 12));
                if (r == 0) exp1++; else exp0++;
            end
            run_until(1500, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd_run%0d: got no completion want done", it); end
            checks++;
            if (data_bad(0) + data_bad(1) != 0) begin
                errors++; $display("FAIL rnd_data%0d: got %0d bad (n=%0d/%0d rx=%0d/%0d) want 0",
                                   it, data_bad(0) + data_bad(1), src_n[0], src_n[1], rx_n[0], rx_n[1]);
            end
            for (int k = 0; k < 2; k++) begin src_n[k] = 0; rx_n[k] = 0; end
        end
        checks++;
        if (done_cnt[0] != exp0 || done_cnt[1] != exp1) begin
            errors++; $display("FAIL rnd_done_count: got %0d/%0d want %0d/%0d", done_cnt[0], done_cnt[1], exp0, exp1);
        end
        checks++;
        if (viol_ready != 0 || px != sx) begin
            errors++; $display("FAIL rnd_handshake: got viol=%0d pr=%0d src=%0d want 0 and equal", viol_ready, px, sx);
        end
        checks++;
        if (viol_freeze != 0) begin errors++; $display("FAIL rnd_freeze: got %0d violations want 0", viol_freeze); end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        do_reset(); clear_stats();
        ip_mode = 0; gaps = 1; rnd_ready = 0;
        load(0, 10);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (rx_n[0] >= 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach_stream: got %0d words want >=2", rx_n[0]); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({grant, freeze, done, err, s_ready} !== 10'b0 || {busy, pr_start, pr_data_valid} !== 3'b000) begin
            errors++; $display("FAIL mid_async_vec: got %b %b want 0", {grant, freeze, done, err, s_ready},
                               {busy, pr_start, pr_data_valid});
        end
        checks++;
        if (pr_data !== '0 || err_code !== 3'b000) begin
            errors++; $display("FAIL mid_async_data: got data=%h code=%b want 0", pr_data, err_code);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        gaps = 0;
        load(0, 3);
        run_until(300, ok);
        checks++;
        if (!ok || done_cnt[0] != 1 || data_bad(0) != 0) begin
            errors++; $display("FAIL mid_recover: got ok=%0d done=%0d bad=%0d want 1/1/0", ok, done_cnt[0], data_bad(0));
        end
    endtask

    initial begin
        cyc = 0;
        ip_mode = 0; gaps = 0; rnd_ready = 0; err_at = 0; err_val = 3'b000;
        clear_stats();
        test_reset();
        test_single();
        test_contention();
        test_stream_error();
        test_timeout();
        test_random_stream();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pr_sched.md
Name: pr_sched

Overview:
- Scheduler that shares one partial-reconfiguration controller (pr_ip) between two PR regions (requesters 0 and 1).
- Arbitrates requests round-robin, freezes the target region, and pulses pr_start.
- Streams the granted requester's 16-bit bitstream into pr_ip, monitors pr_ip status, then unfreezes the region and reports done or error.
- Sits in top between the bitstream sources and the pr_ip instance.

Parameters:
- FREEZE_CYCLES, 16: settle cycles between freeze assertion and pr_start.
- TIMEOUT_CYCLES, 1000000: max cycles in any wait state before a timeout error.
- DATA_W, 16: bitstream word width; must match pr_ip data.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  2  per-requester reconfiguration request; level, held until done/err
- s_data  in  2x DATA_W  per-requester bitstream word
- s_valid  in  2  per-requester word valid
- s_last  in  2  marks final bitstream word
- s_ready  out  2  per-requester word accepted
- done  out  2  one-cycle pulse: PR of that region succeeded
- err  out  2  one-cycle pulse: PR of that region failed
- err_code  out  3  code of most recent failure
- grant  out  2  one-hot current owner; 0 when idle
- busy  out  1  state != IDLE
- freeze  out  2  per-region freeze, drives pr_ip_instN.freeze
- pr_start  out  1  to pr_ip.pr_start
- pr_data  out  DATA_W  to pr_ip.data
- pr_data_valid  out  1  to pr_ip.data_valid
- pr_data_ready  in  1  from pr_ip.data_ready
- pr_status  in  3  from pr_ip.status

Behaviour:
- Reset (async, any state, including mid-stream): state = IDLE; the round-robin pointer favours requester 0.
  - All outputs = 0: freeze, pr_start, done, err, err_code, grant, busy, s_ready, pr_data_valid, pr_data.
- pr_status codes:
  - 000 idle/power-up
  - 001 PR_ERROR
  - 010 CRC_ERROR
  - 011 incompatible bitstream
  - 100 in progress
  - 101 success
  - 110/111 are reserved and treated as idle. Internal code ERR_TIMEOUT = 111.
- IDLE: req is sampled only here.
  - If only one request is present, that requester is granted.
  - If both are present, the pointer holder wins and the pointer then moves to the other requester.
  - Grant is registered and enters FREEZE the next cycle.
- FREEZE: freeze[g] = 1 from entry. After FREEZE_CYCLES cycles -> START.
- START: pr_start = 1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY:
  - status 100 -> STREAM.
  - status 001/010/011 -> FAIL with that code.
  - timeout -> FAIL with 111.
- STREAM: combinational pass-through for the granted requester g:
  - pr_data = s_data[g], pr_data_valid = s_valid[g], s_ready[g] = pr_data_ready.
  - Non-granted s_ready = 0.
  - A transfer is a cycle with valid & ready.
  - A transfer with s_last[g] = 1 -> WAIT_DONE.
  - Error status -> FAIL immediately; stream stops and pr_data_valid = 0 from the next cycle.
  - The timeout counter restarts on every transfer.
- WAIT_DONE:
  - status 101 -> RELEASE_OK.
  - error status -> FAIL.
  - timeout -> FAIL with 111.
- FAIL: latch err_code -> RELEASE_ERR.
- RELEASE_OK / RELEASE_ERR: freeze[g] = 0, and done[g] or err[g] is pulsed in the same cycle -> IDLE.
  - Freeze is always released, even on error.
  - err_code holds until the next failure.
- Timeout counter: cleared on every state entry; saturating, width $clog2(TIMEOUT_CYCLES+1).
- Invariants:
  - freeze is one-hot or zero.
  - Only the granted region is ever frozen.
  - grant is stable from FREEZE through RELEASE.
- Dropping req mid-operation is ignored: the transaction completes or fails normally. No abort.
- Latency: grant-to-pr_start = FREEZE_CYCLES + 2 cycles.

Decomposition:
- pr_sched_pkg holds:
  - the state enum: IDLE, FREEZE, START, WAIT_BUSY, STREAM, WAIT_DONE, FAIL, RELEASE_OK, RELEASE_ERR;
  - localparams for the pr_status codes and ERR_TIMEOUT.
- Sub-module rr_arb2: two-input round-robin arbiter. Inputs: req, advance. Outputs: one-hot grant, pointer.

Test Plan:
- req=01, 4-word stream with last on word 3; model status 100 after pr_start, then 101 → freeze[0] high ≥ 16 cycles before pr_start, 4 words on pr_data in order, done[0] pulse, freeze=00 afterwards, err_code=000.
- req=11 from reset → requester 0 served first and requester 1 immediately after; then req=11 again → requester 1 wins.
- Status 010 mid-stream → pr_data_valid=0 next cycle, err[g] pulse, err_code=010, freeze released.
- TIMEOUT_CYCLES=50, pr_status stuck at 000 after pr_start → err pulse after 50 cycles, err_code=111.
- pr_data_ready toggled randomly and s_valid gapped → every word transferred exactly once, no duplicates; s_ready of the non-granted requester stays 0.
- Assert rst during STREAM → all outputs 0 asynchronously; after release, a new req completes normally.
